// File: rtl/lift_coeff_if.sv
// Control and RAM-side bus of the coefficient-lift engine.
// The engine attaches through the slave modport, and its controller/RAM side through the master modport.
interface lift_coeff_if #(
  parameter int unsigned COEF_W = 13,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LANES  = 1
);
  localparam int unsigned DATA_W = LANES * COEF_W;

  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] last_addr;
  logic              busy;
  logic              done;
  logic              err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    output start, mode, last_addr, rd_data,
    input  busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  start, mode, last_addr, rd_data,
    output busy, done, err, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/lift_coeff_engine.sv
// Streaming coefficient-lift engine: reads packed words, maps every lane, and writes each word back two cycles after its read.
// Modes: 0 ternary lift, 1 centre, 2 negate mod Q, 3 copy.
module lift_coeff_engine #(
  parameter int unsigned COEF_W = 13,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned LANES  = 1,
  parameter int unsigned Q      = 4591
) (
  input  logic        clk,
  input  logic        rst,
  lift_coeff_if.slave bus
);
  localparam int unsigned DATA_W = LANES * COEF_W;
  localparam int unsigned HALF   = (Q - 1) / 2;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_mode;
  logic [ADDR_W-1:0] r_last;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_p1_vld;
  logic [ADDR_W-1:0] r_p1_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_busy;
  logic              r_done;
  logic              r_err;

  logic              w_accept;
  logic              w_rd_en_nxt;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [DATA_W-1:0] w_mapped;
  logic              w_bad;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state and next registered control outputs
  always_comb begin
    w_state_nxt   = r_state;
    w_accept      = 1'b0;
    w_rd_en_nxt   = 1'b0;
    w_rd_addr_nxt = r_rd_addr;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept      = 1'b1;
          w_state_nxt   = S_RUN;
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = '0;
          w_busy_nxt    = 1'b1;
        end
      end
      S_RUN: begin
        // Compare the address just issued, so a full-range run never wraps
        if (r_rd_addr == r_last) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_rd_en_nxt   = 1'b1;
          w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (!r_p1_vld) begin
          w_state_nxt = S_DONE;
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Per-lane mapping of the word returned by the RAM this cycle
  always_comb begin
    logic [COEF_W-1:0] v;
    logic [COEF_W-1:0] m;
    w_mapped = '0;
    w_bad    = 1'b0;
    v        = '0;
    m        = '0;
    for (int j = 0; j < int'(LANES); j++) begin
      v = bus.rd_data[j*COEF_W +: COEF_W];
      case (r_mode)
        2'd0: begin
          if (v == COEF_W'(0))      m = '0;
          else if (v == COEF_W'(1)) m = COEF_W'(1);
          else if (v == COEF_W'(2)) m = COEF_W'(Q - 1);
          else begin
            m     = '0;
            w_bad = 1'b1;
          end
        end
        2'd1: begin
          if (v > COEF_W'(HALF)) m = COEF_W'({1'b0, v} - (COEF_W+1)'(Q));
          else                   m = v;
        end
        2'd2: begin
          if (v == COEF_W'(0)) m = '0;
          else                 m = COEF_W'((COEF_W+1)'(Q) - {1'b0, v});
        end
        default: m = v;
      endcase
      w_mapped[j*COEF_W +: COEF_W] = m;
    end
  end

  // Read issue, one-stage data return, registered write-back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode    <= 2'd0;
      r_last    <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_p1_vld  <= 1'b0;
      r_p1_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_mode <= bus.mode;
        r_last <= bus.last_addr;
      end
      r_rd_en   <= w_rd_en_nxt;
      r_rd_addr <= w_rd_addr_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_p1_vld  <= r_rd_en;
      r_p1_addr <= r_rd_addr;
      r_wr_en   <= r_p1_vld;
      if (r_p1_vld) begin
        r_wr_addr <= r_p1_addr;
        r_wr_data <= w_mapped;
      end
      if (w_accept)                                   r_err <= 1'b0;
      else if (r_p1_vld && (r_mode == 2'd0) && w_bad) r_err <= 1'b1;
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.err     = r_err;
  assign bus.rd_en   = r_rd_en;
  assign bus.rd_addr = r_rd_addr;
  assign bus.wr_en   = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;

endmodule

// File: tb/tb_lift_coeff_engine.sv
// Directed bench for lift_coeff_engine with two lanes per word and a 1-cycle-latency RAM model.
module tb_lift_coeff_engine;
  localparam int unsigned COEF_W = 13;
  localparam int unsigned ADDR_W = 11;
  localparam int unsigned LANES  = 2;
  localparam int unsigned Q      = 4591;
  localparam int unsigned DW     = LANES * COEF_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [DW-1:0]     mem [0:(2**ADDR_W)-1];
  logic              ld_en   = 1'b0;
  logic [ADDR_W-1:0] ld_addr = '0;
  logic [DW-1:0]     ld_data = '0;

  int t0, nw, wfirst, wlast, nb, bfirst, blast, nd, dcyc, seqbad;

  lift_coeff_if #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .LANES(LANES)) bus ();

  lift_coeff_engine #(.COEF_W(COEF_W), .ADDR_W(ADDR_W), .LANES(LANES), .Q(Q)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: read latency 1, bench preload port takes priority over the engine write
  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    if (ld_en)             mem[ld_addr]     <= ld_data;
    else if (bus.wr_en)    mem[bus.wr_addr] <= bus.wr_data;
  end

  function automatic logic [DW-1:0] w2(input int hi, input int lo);
    return {COEF_W'(hi), COEF_W'(lo)};
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic load(input int a, input logic [DW-1:0] d);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_addr = ADDR_W'(a);
    ld_data = d;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Start one run and record write/busy/done timing relative to the start cycle
  task automatic run(input logic [1:0] m, input int last);
    bit fin;
    int rel;
    @(negedge clk);
    bus.mode      = m;
    bus.last_addr = ADDR_W'(last);
    bus.start     = 1'b1;
    t0 = cyc;
    nw = 0; wfirst = -1; wlast = -1; nb = 0; bfirst = -1; blast = -1;
    nd = 0; dcyc = -1; seqbad = 0;
    @(negedge clk);
    bus.start = 1'b0;
    fin = 1'b0;
    for (int k = 0; k < last + 20 && !fin; k++) begin
      rel = cyc - t0;
      if (bus.wr_en) begin
        if (nw == 0) wfirst = rel;
        wlast = rel;
        if (int'(bus.wr_addr) != nw) seqbad++;
        nw++;
      end
      if (bus.busy) begin
        if (nb == 0) bfirst = rel;
        blast = rel;
        nb++;
      end
      if (bus.done) begin
        nd++;
        dcyc = rel;
        fin  = 1'b1;
      end
      if (!fin) @(negedge clk);
    end
    if (!fin) chk("done_timeout", 0, 1);
  endtask

  task automatic chk_timing(input string tag, input int n);
    chk({tag, "_nwrites"},   nw,     n);
    chk({tag, "_wr_first"},  wfirst, 3);
    chk({tag, "_wr_last"},   wlast,  n + 2);
    chk({tag, "_wr_seq"},    seqbad, 0);
    chk({tag, "_done_at"},   dcyc,   n + 3);
    chk({tag, "_busy_from"}, bfirst, 1);
    chk({tag, "_busy_to"},   blast,  n + 2);
    chk({tag, "_busy_cnt"},  nb,     n + 2);
  endtask

  initial begin
    int nd_after, nw_after;
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.last_addr = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy",    int'(bus.busy),    0);
    chk("rst_done",    int'(bus.done),    0);
    chk("rst_err",     int'(bus.err),     0);
    chk("rst_rd_en",   int'(bus.rd_en),   0);
    chk("rst_wr_en",   int'(bus.wr_en),   0);
    chk("rst_rd_addr", int'(bus.rd_addr), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    chk("rst_wr_data", int'(bus.wr_data), 0);
    rst = 1'b0;

    // Mode 0 ternary lift over three words
    load(0, w2(2, 1));
    load(1, w2(0, 2));
    load(2, w2(1, 0));
    run(2'd0, 2);
    chk_timing("m0", 3);
    chk("m0_mem0", int'(mem[0]), int'(w2(4590, 1)));
    chk("m0_mem1", int'(mem[1]), int'(w2(0, 4590)));
    chk("m0_mem2", int'(mem[2]), int'(w2(1, 0)));
    chk("m0_err",  int'(bus.err), 0);

    // Mode 0 with one illegal lane, then a clean run clears err
    load(0, w2(5, 1));
    run(2'd0, 0);
    chk_timing("m0bad", 1);
    chk("m0bad_mem0", int'(mem[0]), int'(w2(0, 1)));
    chk("m0bad_err",  int'(bus.err), 1);
    load(0, w2(0, 2));
    run(2'd0, 0);
    chk("m0clr_mem0", int'(mem[0]), int'(w2(0, 4590)));
    chk("m0clr_err",  int'(bus.err), 0);

    // Mode 1 centring around the (Q-1)/2 threshold, including Q-1 -> -1
    load(0, w2(2295, 2296));
    load(1, w2(0, 4590));
    run(2'd1, 1);
    chk("m1_mem0", int'(mem[0]), int'(w2(2295, 5897)));
    chk("m1_mem1", int'(mem[1]), int'(w2(0, 8191)));
    chk("m1_err",  int'(bus.err), 0);

    // Mode 2 negation mod Q
    load(0, w2(0, 1));
    load(1, w2(4590, 2295));
    run(2'd2, 1);
    chk_timing("m2", 2);
    chk("m2_mem0", int'(mem[0]), int'(w2(0, 4590)));
    chk("m2_mem1", int'(mem[1]), int'(w2(1, 2296)));

    // Extra start during busy is ignored, then reset aborts at t+3
    @(negedge clk);
    bus.mode      = 2'd3;
    bus.last_addr = ADDR_W'(9);
    bus.start     = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.last_addr = ADDR_W'(0);
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign_rd_addr", int'(bus.rd_addr), 2);
    chk("ign_wr_en",   int'(bus.wr_en),   1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_busy",  int'(bus.busy),  0);
    chk("abort_rd_en", int'(bus.rd_en), 0);
    nd_after = 0;
    nw_after = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.done)  nd_after++;
      if (bus.wr_en) nw_after++;
    end
    chk("abort_no_done",  nd_after, 0);
    chk("abort_no_write", nw_after, 0);

    // Normal run after the abort, then back-to-back with start right after done
    run(2'd3, 2);
    chk_timing("post", 3);
    run(2'd3, 4);
    chk_timing("b2b", 5);

    // Full address range, no wrap
    run(2'd3, (2**ADDR_W) - 1);
    chk("full_nwrites", nw,     2**ADDR_W);
    chk("full_seq",     seqbad, 0);
    chk("full_done_at", dcyc,   (2**ADDR_W) + 3);
    chk("full_ndone",   nd,     1);
    nd_after = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.done) nd_after++;
    end
    chk("full_single_done", nd_after, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1);
  end

endmodule
